mux_nx1_rr: RTL and testbench
=============================

Name: mux_nx1_rr

Overview:
- Parametrised N-lane to 1 merging multiplexer, successor of the 2-lane byte mux in the striping/unstriping datapath.
- Each lane has a small input FIFO.
- A round-robin scheduler drains one byte per clk_2f cycle into a registered, valid-qualified output.
- Sits at the faster clock domain boundary, recombining striped lanes into a single byte stream.

Parameters:
- LANES, 4, number of input lanes (2..8).
- WIDTH, 8, data bits per lane and at the output.
- DEPTH, 4, entries per lane FIFO; must be a power of 2, at least 2.

Ports:
- clk_2f  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- valid_in  input  LANES  bit i qualifies lane i data this cycle.
- clear_ovf  input  1  synchronous clear of all overflow flags.
- data_out  output  WIDTH  merged data, registered.
- valid_out  output  1  data_out is a new byte this cycle, registered.
- lane_out  output  max(1,$clog2(LANES))  source lane of data_out, registered.
- full  output  LANES  bit i = lane i FIFO holds DEPTH entries; derived from registers only.
- overflow  output  LANES  sticky: lane i dropped a write.

Behaviour:
- Reset (sampled high on an edge):
  - data_out=0, valid_out=0, lane_out=0, overflow=0.
  - All FIFOs empty; round-robin pointer rr=0.
  - Reset dominates all other inputs; in-flight FIFO contents are discarded.
- Write side, per lane:
  - valid_in[i]=1 pushes data_in lane i at the edge.
  - If FIFO i is full and not popped that cycle: the write is dropped and overflow[i] is set.
  - If full and popped the same cycle: the write is accepted; count is unchanged.
  - Push and pop on the same lane and cycle are always legal.
- Read side, base mode (strict order, macro undefined):
  - If FIFO[rr] is non-empty: pop its head. Next cycle data_out=head, lane_out=rr, valid_out=1. rr advances, wrapping LANES-1 -> 0.
  - If FIFO[rr] is empty: valid_out=0 next cycle and rr holds. This stall preserves striping byte order.
- When valid_out=0, data_out and lane_out hold their previous values.
- Latency: a byte pushed at edge k into an empty, selected FIFO is popped at edge k+1 and is visible on data_out after edge k+1. A FIFO write is never bypassed to the output in the same cycle.
- Ordering: FIFO is first-in-first-out per lane; pointers wrap modulo DEPTH; count width is $clog2(DEPTH)+1.
- clear_ovf=1: clears all overflow bits at the edge. A drop in the same cycle wins, so that bit stays set.
- Throughput: at most one output byte per cycle. Aggregate input above one byte per cycle eventually fills the FIFOs.

Optional Feature:
- Macro MUX_SKIP_EMPTY_EN.
- Defined (work-conserving scheduling):
  - Each cycle, search lanes cyclically starting at rr for the first non-empty FIFO.
  - Pop it, output as above, then set rr = chosen+1 mod LANES.
  - If all FIFOs are empty: valid_out=0 and rr holds.
- Undefined: strict-order behaviour above. Empty lanes stall the output and are never skipped.
- Ports, latency and overflow rules are identical in both builds.

Test Plan:
- Reset: assert reset 2 cycles with all valid_in=1.
  - Expect all outputs 0, full=0, overflow=0.
  - First pop after deassert comes from lane 0.
- Strict round robin, LANES=4: one cycle of valid_in=4'b1111, data 0x11/0x22/0x33/0x44.
  - Expect valid_out bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles, lane_out 0..3.
  - The first byte appears 2 edges after the push.
- Strict stall: push only lane 0 (0xA0) and lane 2 (0xC2).
  - Expect 0xA0, then valid_out=0 indefinitely; rr stays at 1.
  - A later push of 0xB1 on lane 1 yields 0xB1, then 0xC2.
- Overflow: hold valid_in[3]=1 for DEPTH+3 cycles while the other lanes are empty (strict mode).
  - Expect full[3]=1 after DEPTH pushes and overflow[3]=1.
  - Other overflow bits stay 0.
  - clear_ovf pulse with no drop that cycle clears the flag.
- Skip mode (MUX_SKIP_EMPTY_EN): same stimulus as the strict stall test.
  - Expect 0xA0, then 0xC2 on back-to-back cycles with lane_out 0, 2.
  - Then valid_out=0.
- Mid-operation reset: reset asserted with 3 bytes queued.
  - Expect valid_out=0 the next cycle and the queued bytes are never emitted.

Source files
------------

// File: rtl/mux_nx1_rr_if.sv
// Lane-side and merged-side signal bundle for mux_nx1_rr.
// master = traffic source/sink around the mux, slave = the mux itself.
interface mux_nx1_rr_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES*WIDTH-1:0] data_in;
  logic [LANES-1:0]       valid_in;
  logic                   clear_ovf;
  logic [WIDTH-1:0]       data_out;
  logic                   valid_out;
  logic [LW-1:0]          lane_out;
  logic [LANES-1:0]       full;
  logic [LANES-1:0]       overflow;

  modport master (
    output data_in, valid_in, clear_ovf,
    input  data_out, valid_out, lane_out, full, overflow
  );

  modport slave (
    input  data_in, valid_in, clear_ovf,
    output data_out, valid_out, lane_out, full, overflow
  );
endinterface

// File: rtl/mux_nx1_rr.sv
// N-lane to 1 merging mux: per-lane FIFOs drained one byte per clk_2f by a round-robin pointer.
// Define MUX_SKIP_EMPTY_EN for work-conserving scheduling; default stalls on an empty lane.
module mux_nx1_rr #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic         clk_2f,
  input logic         reset,
  mux_nx1_rr_if.slave bus
);
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q    [LANES][DEPTH];
  logic [PW-1:0]    wr_ptr_q [LANES];
  logic [PW-1:0]    rd_ptr_q [LANES];
  logic [CW-1:0]    cnt_q    [LANES];
  logic [CW-1:0]    cnt_d    [LANES];

  logic [LW-1:0]    rr_q, rr_d, sel;
  logic             pop_any;
  logic [WIDTH-1:0] head;
  logic [LANES-1:0] pop, push, drop, full_w;

  logic [WIDTH-1:0] data_out_q;
  logic             valid_out_q;
  logic [LW-1:0]    lane_out_q;
  logic [LANES-1:0] ovf_q;

  // Scheduler: pick the lane to pop this cycle.
  always_comb begin
    sel     = rr_q;
    pop_any = 1'b0;
`ifdef MUX_SKIP_EMPTY_EN
    for (int unsigned k = 0; k < LANES; k++) begin
      logic [LW-1:0] cand;
      cand = LW'((32'(rr_q) + k) % LANES);
      if (!pop_any && (cnt_q[cand] != '0)) begin
        pop_any = 1'b1;
        sel     = cand;
      end
    end
`else
    pop_any = (cnt_q[rr_q] != '0);
`endif
    pop  = pop_any ? (LANES'(1) << sel) : '0;
    rr_d = rr_q;
    if (pop_any) rr_d = (sel == LW'(LANES - 1)) ? '0 : sel + LW'(1);
    head = mem_q[sel][rd_ptr_q[sel]];
  end

  // A full lane still accepts a write when it is popped in the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      full_w[i] = (cnt_q[i] == CW'(DEPTH));
      push[i]   = bus.valid_in[i] && (!full_w[i] || pop[i]);
      drop[i]   = bus.valid_in[i] && full_w[i] && !pop[i];
      cnt_d[i]  = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      rr_q        <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      lane_out_q  <= '0;
      ovf_q       <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      valid_out_q <= pop_any;
      if (pop_any) begin
        data_out_q <= head;
        lane_out_q <= sel;
      end
      // A drop in the same cycle as clear_ovf keeps its flag set.
      ovf_q <= (bus.clear_ovf ? '0 : ovf_q) | drop;
      for (int unsigned i = 0; i < LANES; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk_2f) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!reset && push[i]) mem_q[i][wr_ptr_q[i]] <= bus.data_in[i*WIDTH +: WIDTH];
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.lane_out  = lane_out_q;
  assign bus.full      = full_w;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed self-checking bench for mux_nx1_rr with LANES=4, WIDTH=8, DEPTH=4.
module tb_mux_nx1_rr;
  logic clk;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  mux_nx1_rr_if #(.LANES(4), .WIDTH(8)) bus ();

  mux_nx1_rr #(.LANES(4), .WIDTH(8), .DEPTH(4)) dut (
    .clk_2f (clk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.valid_in = '0;
    bus.clear_ovf = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.valid_in = 4'b1111;
    bus.data_in = 32'hFFFF_FFFF;
    bus.clear_ovf = 1'b0;
    tick();
    tick();
    checks++; if (bus.data_out !== 8'h00) $display("FAIL reset_data act=%h exp=00", bus.data_out); else passed++;
    checks++; if (bus.valid_out !== 1'b0) $display("FAIL reset_valid act=%b exp=0", bus.valid_out); else passed++;
    checks++; if (bus.lane_out !== 2'd0) $display("FAIL reset_lane act=%0d exp=0", bus.lane_out); else passed++;
    checks++; if (bus.full !== 4'b0000) $display("FAIL reset_full act=%b exp=0000", bus.full); else passed++;
    checks++; if (bus.overflow !== 4'b0000) $display("FAIL reset_ovf act=%b exp=0000", bus.overflow); else passed++;
    reset = 1'b0;
    bus.valid_in = 4'b0011;
    bus.data_in = {8'h00, 8'h00, 8'h6B, 8'h5A};
    tick();
    bus.valid_in = '0;
    checks++; if (bus.valid_out !== 1'b0) $display("FAIL reset_first_latency act=%b exp=0", bus.valid_out); else passed++;
    tick();
    checks++; if (bus.valid_out !== 1'b1 || bus.lane_out !== 2'd0 || bus.data_out !== 8'h5A)
      $display("FAIL reset_first_lane act=%b/%0d/%h exp=1/0/5a", bus.valid_out, bus.lane_out, bus.data_out); else passed++;
    tick();
  endtask

  task automatic test_strict_rr();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    bus.valid_in = 4'b1111;
    bus.data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    bus.valid_in = '0;
    checks++; if (bus.valid_out !== 1'b0) $display("FAIL rr_latency act=%b exp=0", bus.valid_out); else passed++;
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== exp[j] || bus.lane_out !== 2'(j))
        $display("FAIL rr_byte%0d act=%b/%h/%0d exp=1/%h/%0d", j, bus.valid_out, bus.data_out, bus.lane_out, exp[j], j);
      else passed++;
    end
    tick();
    checks++; if (bus.valid_out !== 1'b0) $display("FAIL rr_idle act=%b exp=0", bus.valid_out); else passed++;
  endtask

`ifndef MUX_SKIP_EMPTY_EN
  task automatic test_strict_stall();
    do_reset();
    bus.valid_in = 4'b0101;
    bus.data_in = {8'h00, 8'hC2, 8'h00, 8'hA0};
    tick();
    bus.valid_in = '0;
    tick();
    checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hA0 || bus.lane_out !== 2'd0)
      $display("FAIL stall_first act=%b/%h/%0d exp=1/a0/0", bus.valid_out, bus.data_out, bus.lane_out); else passed++;
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++;
      if (bus.valid_out !== 1'b0 || bus.data_out !== 8'hA0 || bus.lane_out !== 2'd0)
        $display("FAIL stall_hold%0d act=%b/%h/%0d exp=0/a0/0", j, bus.valid_out, bus.data_out, bus.lane_out);
      else passed++;
    end
    bus.valid_in = 4'b0010;
    bus.data_in = {8'h00, 8'h00, 8'hB1, 8'h00};
    tick();
    bus.valid_in = '0;
    checks++; if (bus.valid_out !== 1'b0) $display("FAIL stall_push_lat act=%b exp=0", bus.valid_out); else passed++;
    tick();
    checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hB1 || bus.lane_out !== 2'd1)
      $display("FAIL stall_b1 act=%b/%h/%0d exp=1/b1/1", bus.valid_out, bus.data_out, bus.lane_out); else passed++;
    tick();
    checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hC2 || bus.lane_out !== 2'd2)
      $display("FAIL stall_c2 act=%b/%h/%0d exp=1/c2/2", bus.valid_out, bus.data_out, bus.lane_out); else passed++;
    tick();
    checks++; if (bus.valid_out !== 1'b0) $display("FAIL stall_end act=%b exp=0", bus.valid_out); else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    bus.valid_in = 4'b1000;
    for (int j = 1; j <= 7; j++) begin
      bus.data_in = {8'(8'h30 + j), 24'h0};
      tick();
      checks++;
      if (bus.full !== ((j >= 4) ? 4'b1000 : 4'b0000) || bus.overflow !== ((j > 4) ? 4'b1000 : 4'b0000))
        $display("FAIL ovf_push%0d act=full %b ovf %b exp=full %b ovf %b", j, bus.full, bus.overflow,
                 (j >= 4) ? 4'b1000 : 4'b0000, (j > 4) ? 4'b1000 : 4'b0000);
      else passed++;
    end
    bus.clear_ovf = 1'b1;
    bus.data_in = {8'h3E, 24'h0};
    tick();
    checks++; if (bus.overflow !== 4'b1000) $display("FAIL ovf_clear_vs_drop act=%b exp=1000", bus.overflow); else passed++;
    bus.valid_in = '0;
    tick();
    bus.clear_ovf = 1'b0;
    checks++; if (bus.overflow !== 4'b0000 || bus.full !== 4'b1000)
      $display("FAIL ovf_clear act=ovf %b full %b exp=ovf 0000 full 1000", bus.overflow, bus.full); else passed++;
    bus.valid_in = 4'b0111;
    bus.data_in = {8'h00, 8'h02, 8'h01, 8'h00};
    tick();
    bus.valid_in = '0;
    tick();
    tick();
    tick();
    checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h02 || bus.lane_out !== 2'd2)
      $display("FAIL ovf_drain_l2 act=%b/%h/%0d exp=1/02/2", bus.valid_out, bus.data_out, bus.lane_out); else passed++;
    bus.valid_in = 4'b1000;
    bus.data_in = {8'h3F, 24'h0};
    tick();
    bus.valid_in = '0;
    checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h31 || bus.lane_out !== 2'd3)
      $display("FAIL ovf_fifo_head act=%b/%h/%0d exp=1/31/3", bus.valid_out, bus.data_out, bus.lane_out); else passed++;
    checks++; if (bus.full !== 4'b1000 || bus.overflow !== 4'b0000)
      $display("FAIL ovf_full_pop_push act=full %b ovf %b exp=full 1000 ovf 0000", bus.full, bus.overflow); else passed++;
  endtask
`else
  task automatic test_skip();
    do_reset();
    bus.valid_in = 4'b0101;
    bus.data_in = {8'h00, 8'hC2, 8'h00, 8'hA0};
    tick();
    bus.valid_in = '0;
    tick();
    checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hA0 || bus.lane_out !== 2'd0)
      $display("FAIL skip_a0 act=%b/%h/%0d exp=1/a0/0", bus.valid_out, bus.data_out, bus.lane_out); else passed++;
    tick();
    checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 8'hC2 || bus.lane_out !== 2'd2)
      $display("FAIL skip_c2 act=%b/%h/%0d exp=1/c2/2", bus.valid_out, bus.data_out, bus.lane_out); else passed++;
    tick();
    checks++; if (bus.valid_out !== 1'b0) $display("FAIL skip_idle act=%b exp=0", bus.valid_out); else passed++;
  endtask
`endif

  task automatic test_mid_reset();
    do_reset();
    bus.valid_in = 4'b1110;
    bus.data_in = {8'hD3, 8'hD2, 8'hD1, 8'h00};
    tick();
    bus.valid_in = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.valid_out !== 1'b0 || bus.full !== 4'b0000)
      $display("FAIL midrst_state act=%b/%b exp=0/0000", bus.valid_out, bus.full); else passed++;
    bus.valid_in = 4'b0001;
    bus.data_in = {24'h0, 8'h77};
    tick();
    bus.valid_in = '0;
    tick();
    checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h77 || bus.lane_out !== 2'd0)
      $display("FAIL midrst_fresh act=%b/%h/%0d exp=1/77/0", bus.valid_out, bus.data_out, bus.lane_out); else passed++;
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++; if (bus.valid_out !== 1'b0) $display("FAIL midrst_discard%0d act=%b/%h exp=0", j, bus.valid_out, bus.data_out); else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.valid_in = '0;
    bus.data_in = '0;
    bus.clear_ovf = 1'b0;
    test_reset();
    test_strict_rr();
`ifndef MUX_SKIP_EMPTY_EN
    test_strict_stall();
    test_overflow();
`else
    test_skip();
`endif
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
